bp_me_mem_arbiter: RTL and testbench

Two-to-one BedRock stream arbiter that shares a single memory port (e.g. `bp_nonsynth_mem`) between two cache engines, such as I$ and D$ UCEs in FE/BE unit benches. It grants whole command streams round-robin, locks the grant until the last beat, and records each granted requester in an in-order tracking FIFO. Responses are steered back to the recorded requester, because the memory returns responses in command order.

---
 rtl/bp_me_mem_arbiter_pkg.sv | 31 +++
 rtl/bp_me_mem_arbiter_fifo.sv | 53 +++++
 rtl/bp_me_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_bp_me_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_mem_arbiter_pkg.sv
// Shared types for the two-to-one BedRock memory arbiter: configuration,
// memory header payload and the command FSM states.
package bp_me_mem_arbiter_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  localparam int unsigned paddr_width_p   = 40;
  localparam int unsigned did_width_p     = 3;
  localparam int unsigned lce_id_width_p  = 4;
  localparam int unsigned lce_assoc_p     = 8;
  localparam int unsigned l2_data_width_p = 64;
  localparam int unsigned lce_way_width_p = $clog2(lce_assoc_p);

  typedef struct packed {
    logic [3:0]                 msg_type;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [did_width_p-1:0]     did;
    logic [lce_id_width_p-1:0]  lce_id;
    logic [lce_way_width_p-1:0] way_id;
  } bp_bedrock_mem_header_s;

  typedef enum logic [0:0] {e_idle, e_locked} bp_me_mem_arb_state_e;

  function automatic int unsigned l2_data_width(input bp_params_e cfg);
    case (cfg)
      default: return l2_data_width_p;
    endcase
  endfunction

endpackage

// File: rtl/bp_me_mem_arbiter_fifo.sv
// Small in-order FIFO recording which requester owns each outstanding
// command stream.
module bp_me_mem_arbiter_fifo #(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;

  function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (v_i)    wptr_r <= wrap_inc(wptr_r);
      if (yumi_i) rptr_r <= wrap_inc(rptr_r);
      case ({v_i, yumi_i})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_me_mem_arbiter.sv
// Round-robin, stream-locked 2:1 arbiter sharing one BedRock memory port;
// responses are steered back in command order via a tracking FIFO.
module bp_me_mem_arbiter
  import bp_me_mem_arbiter_pkg::*;
#(
  parameter bp_params_e  bp_params_p       = e_bp_default_cfg,
  parameter int unsigned outstanding_els_p = 4,
  localparam int unsigned dw_lp            = l2_data_width(bp_params_p)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  bp_bedrock_mem_header_s [1:0]      req_mem_cmd_header_i,
  input  logic [1:0][dw_lp-1:0]             req_mem_cmd_data_i,
  input  logic [1:0]                        req_mem_cmd_v_i,
  input  logic [1:0]                        req_mem_cmd_last_i,
  output logic [1:0]                        req_mem_cmd_ready_and_o,

  output bp_bedrock_mem_header_s [1:0]      req_mem_resp_header_o,
  output logic [1:0][dw_lp-1:0]             req_mem_resp_data_o,
  output logic [1:0]                        req_mem_resp_v_o,
  output logic [1:0]                        req_mem_resp_last_o,
  input  logic [1:0]                        req_mem_resp_ready_and_i,

  output bp_bedrock_mem_header_s            mem_cmd_header_o,
  output logic [dw_lp-1:0]                  mem_cmd_data_o,
  output logic                              mem_cmd_v_o,
  output logic                              mem_cmd_last_o,
  input  logic                              mem_cmd_ready_and_i,

  input  bp_bedrock_mem_header_s            mem_resp_header_i,
  input  logic [dw_lp-1:0]                  mem_resp_data_i,
  input  logic                              mem_resp_v_i,
  input  logic                              mem_resp_last_i,
  output logic                              mem_resp_ready_and_o
);

  bp_me_mem_arb_state_e state_r, state_n;
  logic grant_r, grant_n, rr_r, rr_n;
  logic gnt, gnt_v, cmd_hs, push, pop;
  logic fifo_ready, fifo_v, fifo_head;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      grant_r <= 1'b0;
      rr_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      rr_r    <= rr_n;
    end
  end

  // Grant is combinational in idle; locked holds the owner until its last beat.
  always_comb begin
    state_n = state_r;
    grant_n = grant_r;
    rr_n    = rr_r;
    gnt     = grant_r;
    gnt_v   = 1'b0;
    case (state_r)
      e_idle: begin
        gnt   = req_mem_cmd_v_i[rr_r] ? rr_r : ~rr_r;
        gnt_v = (|req_mem_cmd_v_i) & fifo_ready;
      end
      e_locked: gnt_v = 1'b1;
      default: ;
    endcase
    mem_cmd_v_o = gnt_v & req_mem_cmd_v_i[gnt] & ~reset_i;
    cmd_hs      = mem_cmd_v_o & mem_cmd_ready_and_i;
    if (cmd_hs) begin
      if (req_mem_cmd_last_i[gnt]) begin
        state_n = e_idle;
        rr_n    = ~gnt;
      end else if (state_r == e_idle) begin
        state_n = e_locked;
        grant_n = gnt;
      end
    end
  end

  assign push             = cmd_hs & (state_r == e_idle);
  assign mem_cmd_header_o = req_mem_cmd_header_i[gnt];
  assign mem_cmd_data_o   = req_mem_cmd_data_i[gnt];
  assign mem_cmd_last_o   = req_mem_cmd_last_i[gnt];

  always_comb begin
    req_mem_cmd_ready_and_o      = '0;
    req_mem_cmd_ready_and_o[gnt] = gnt_v & mem_cmd_ready_and_i & ~reset_i;
  end

  // Memory answers in command order, so the FIFO head names the response owner.
  always_comb begin
    req_mem_resp_v_o            = '0;
    req_mem_resp_v_o[fifo_head] = mem_resp_v_i & fifo_v & ~reset_i;
  end

  assign req_mem_resp_header_o = {2{mem_resp_header_i}};
  assign req_mem_resp_data_o   = {2{mem_resp_data_i}};
  assign req_mem_resp_last_o   = {2{mem_resp_last_i}};
  assign mem_resp_ready_and_o  = req_mem_resp_ready_and_i[fifo_head] & fifo_v & ~reset_i;
  assign pop                   = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

  bp_me_mem_arbiter_fifo #(
    .width_p (1),
    .els_p   (outstanding_els_p)
  ) tracker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (gnt),
    .v_i     (push),
    .ready_o (fifo_ready),
    .data_o  (fifo_head),
    .v_o     (fifo_v),
    .yumi_i  (pop)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(mem_resp_v_i && !fifo_v))
        else $error("bp_me_mem_arbiter: memory response with no outstanding command");
  end
`endif

endmodule

// File: tb/tb_bp_me_mem_arbiter.sv
// Randomized bench for bp_me_mem_arbiter against a queue-based reference model.
module tb_bp_me_mem_arbiter;
  import bp_me_mem_arbiter_pkg::*;

  localparam int unsigned DW    = l2_data_width_p;
  localparam int unsigned DEPTH = 4;

  logic clk, reset_i;
  bp_bedrock_mem_header_s [1:0] req_mem_cmd_header_i, req_mem_resp_header_o;
  logic [1:0][DW-1:0] req_mem_cmd_data_i, req_mem_resp_data_o;
  logic [1:0] req_mem_cmd_v_i, req_mem_cmd_last_i, req_mem_cmd_ready_and_o;
  logic [1:0] req_mem_resp_v_o, req_mem_resp_last_o, req_mem_resp_ready_and_i;
  bp_bedrock_mem_header_s mem_cmd_header_o, mem_resp_header_i;
  logic [DW-1:0] mem_cmd_data_o, mem_resp_data_i;
  logic mem_cmd_v_o, mem_cmd_last_o, mem_cmd_ready_and_i;
  logic mem_resp_v_i, mem_resp_last_i, mem_resp_ready_and_o;

  bp_me_mem_arbiter #(.bp_params_p(e_bp_default_cfg), .outstanding_els_p(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_mem_cmd_header_i(req_mem_cmd_header_i), .req_mem_cmd_data_i(req_mem_cmd_data_i),
    .req_mem_cmd_v_i(req_mem_cmd_v_i), .req_mem_cmd_last_i(req_mem_cmd_last_i),
    .req_mem_cmd_ready_and_o(req_mem_cmd_ready_and_o),
    .req_mem_resp_header_o(req_mem_resp_header_o), .req_mem_resp_data_o(req_mem_resp_data_o),
    .req_mem_resp_v_o(req_mem_resp_v_o), .req_mem_resp_last_o(req_mem_resp_last_o),
    .req_mem_resp_ready_and_i(req_mem_resp_ready_and_i),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_data_o(mem_cmd_data_o),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_last_o(mem_cmd_last_o),
    .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
    .mem_resp_header_i(mem_resp_header_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_last_i(mem_resp_last_i),
    .mem_resp_ready_and_o(mem_resp_ready_and_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, failures;

  // Traffic knobs (percentages) and requester/memory stimulus state
  bit [1:0] lane_en;
  int p_start, p_drop, p_mready, p_rvalid;
  int p_rready[2];
  bit withhold, new_ok, force_start;
  int act[2], nbeats[2], beat[2], seq[2];
  bp_bedrock_mem_header_s hdr_d[2];
  bp_bedrock_mem_header_s resp_hq[$];
  int resp_nb[$];
  int mbeat;
  bit mem_first;
  bp_bedrock_mem_header_s mem_cur_hdr;
  bit lane_hs[2];

  // Reference model: lock owner, round-robin pointer, owners of outstanding streams
  bit m_locked, m_owner, m_rr;
  bit owner_q[$];
  int exp_seq[2];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    bit gv, g, mv, have, h;
    if (reset_i) begin
      check_eq("rst_mem_cmd_v", 128'(mem_cmd_v_o), 128'(0));
      check_eq("rst_cmd_ready", 128'(req_mem_cmd_ready_and_o), 128'(0));
      check_eq("rst_resp_v", 128'(req_mem_resp_v_o), 128'(0));
      check_eq("rst_mem_resp_ready", 128'(mem_resp_ready_and_o), 128'(0));
      m_locked = 0; m_owner = 0; m_rr = 0;
      owner_q.delete(); resp_hq.delete(); resp_nb.delete();
      mbeat = 0; mem_first = 1;
      exp_seq[0] = 0; exp_seq[1] = 0;
      lane_hs[0] = 0; lane_hs[1] = 0;
      return;
    end
    gv = 0; g = 0;
    if (m_locked) begin
      gv = 1; g = m_owner;
    end else if (req_mem_cmd_v_i != 2'b00 && owner_q.size() < DEPTH) begin
      gv = 1; g = req_mem_cmd_v_i[m_rr] ? m_rr : !m_rr;
    end
    mv = gv && req_mem_cmd_v_i[g];
    check_eq("mem_cmd_v", 128'(mem_cmd_v_o), 128'(mv));
    for (int l = 0; l < 2; l++)
      check_eq("cmd_ready", 128'(req_mem_cmd_ready_and_o[l]),
               128'(gv && (int'(g) == l) && mem_cmd_ready_and_i));
    if (mv) begin
      check_eq("cmd_header", 128'(mem_cmd_header_o), 128'(req_mem_cmd_header_i[g]));
      check_eq("cmd_data", 128'(mem_cmd_data_o), 128'(req_mem_cmd_data_i[g]));
      check_eq("cmd_last", 128'(mem_cmd_last_o), 128'(req_mem_cmd_last_i[g]));
    end

    have = owner_q.size() > 0;
    h    = have ? owner_q[0] : 1'b0;
    for (int l = 0; l < 2; l++)
      check_eq("resp_v", 128'(req_mem_resp_v_o[l]), 128'(mem_resp_v_i && have && (int'(h) == l)));
    check_eq("mem_resp_ready", 128'(mem_resp_ready_and_o), 128'(have && req_mem_resp_ready_and_i[h]));
    // End to end: each delivered beat belongs to this lane and arrives in its issue order
    for (int l = 0; l < 2; l++) begin
      if (req_mem_resp_v_o[l] && req_mem_resp_ready_and_i[l]) begin
        check_eq("resp_lane", 128'(req_mem_resp_header_o[l].addr[20]), 128'(l));
        check_eq("resp_seq", 128'(req_mem_resp_header_o[l].addr[19:6]), 128'(exp_seq[l] % 16384));
        check_eq("resp_data", 128'(req_mem_resp_data_o[l]), 128'(mem_resp_data_i));
        if (req_mem_resp_last_o[l]) exp_seq[l]++;
      end
    end

    if (have && mem_resp_v_i && req_mem_resp_ready_and_i[h] && mem_resp_last_i)
      void'(owner_q.pop_front());
    if (mv && mem_cmd_ready_and_i) begin
      if (!m_locked) owner_q.push_back(g);
      if (req_mem_cmd_last_i[g]) begin
        m_locked = 0; m_rr = !g;
      end else begin
        m_locked = 1; m_owner = g;
      end
    end

    // Memory and requester bookkeeping from observed handshakes
    for (int l = 0; l < 2; l++) lane_hs[l] = req_mem_cmd_v_i[l] && req_mem_cmd_ready_and_o[l];
    if (mem_cmd_v_o && mem_cmd_ready_and_i) begin
      if (mem_first) mem_cur_hdr = mem_cmd_header_o;
      if (mem_cmd_last_o) begin
        resp_hq.push_back(mem_cur_hdr);
        resp_nb.push_back(int'($urandom_range(2, 1)));
        mem_first = 1;
      end else begin
        mem_first = 0;
      end
    end
    if (mem_resp_v_i && mem_resp_ready_and_o && resp_hq.size() > 0) begin
      if (mem_resp_last_i) begin
        void'(resp_hq.pop_front()); void'(resp_nb.pop_front()); mbeat = 0;
      end else begin
        mbeat++;
      end
    end
  endtask

  task automatic drive();
    if (reset_i) begin
      for (int l = 0; l < 2; l++) begin act[l] = 0; seq[l] = 0; end
      req_mem_cmd_v_i = '0; req_mem_cmd_last_i = '0;
      mem_resp_v_i = 0; mem_resp_last_i = 0;
      req_mem_resp_ready_and_i = '0; mem_cmd_ready_and_i = 0;
      return;
    end
    for (int l = 0; l < 2; l++) begin
      if (lane_hs[l]) begin
        beat[l]++;
        if (beat[l] == nbeats[l]) act[l] = 0;
      end
      if (act[l] == 0 && new_ok && lane_en[l] && ($urandom_range(99) < p_start || force_start)) begin
        act[l] = 1; beat[l] = 0;
        nbeats[l] = int'($urandom_range(4, 1));
        hdr_d[l] = '0;
        hdr_d[l].msg_type = (nbeats[l] > 1) ? 4'd1 : 4'd0;
        hdr_d[l].size     = 3'($urandom_range(7));
        hdr_d[l].addr     = 40'h00_8000_0000 | (40'(l) << 20) | (40'(seq[l] % 16384) << 6);
        hdr_d[l].did      = 3'($urandom);
        hdr_d[l].lce_id   = 4'(l);
        hdr_d[l].way_id   = 3'($urandom);
        seq[l]++;
      end
      req_mem_cmd_v_i[l]      = (act[l] != 0) && ($urandom_range(99) >= p_drop);
      req_mem_cmd_header_i[l] = hdr_d[l];
      req_mem_cmd_data_i[l]   = DW'({$urandom(), $urandom()});
      req_mem_cmd_last_i[l]   = (beat[l] == nbeats[l] - 1);
      req_mem_resp_ready_and_i[l] = ($urandom_range(99) < p_rready[l]);
    end
    force_start = 0;
    mem_cmd_ready_and_i = ($urandom_range(99) < p_mready);
    mem_resp_v_i = (resp_hq.size() > 0) && !withhold && ($urandom_range(99) < p_rvalid);
    if (resp_hq.size() > 0) begin
      mem_resp_header_i = resp_hq[0];
      mem_resp_last_i   = (mbeat == resp_nb[0] - 1);
    end else begin
      mem_resp_last_i = 0;
    end
    mem_resp_data_i = DW'({$urandom(), $urandom()});
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset_i = 1;
    cycle();
    reset_i = 0;
    force_start = 1;
  endtask

  task automatic knobs(input int ps, input int pd, input int pm, input int pv, input int pr0, input int pr1);
    p_start = ps; p_drop = pd; p_mready = pm; p_rvalid = pv; p_rready[0] = pr0; p_rready[1] = pr1;
  endtask

  initial begin
    bit done;
    checks = 0; failures = 0;
    reset_i = 1;
    req_mem_cmd_header_i = '0; req_mem_cmd_data_i = '0; req_mem_cmd_v_i = '0; req_mem_cmd_last_i = '0;
    req_mem_resp_ready_and_i = '0; mem_cmd_ready_and_i = 0;
    mem_resp_header_i = '0; mem_resp_data_i = '0; mem_resp_v_i = 0; mem_resp_last_i = 0;
    withhold = 0; new_ok = 1; force_start = 0; lane_en = 2'b11;
    knobs(50, 0, 100, 100, 100, 100);
    cycle();
    do_reset();

    // Contention from reset, then lane 0 only
    run(40);
    lane_en = 2'b01; knobs(40, 0, 80, 80, 90, 90); run(200);
    // Both lanes busy with random backpressure
    lane_en = 2'b11; knobs(60, 10, 70, 70, 70, 70); run(600);
    // Responses withheld so the tracker fills, then released
    withhold = 1; knobs(80, 0, 100, 100, 100, 100); run(120);
    withhold = 0; run(300);
    // Lane 1 mostly refuses responses
    knobs(60, 5, 90, 90, 90, 8); run(400);
    // Heavy valid dropping between beats
    knobs(70, 50, 80, 80, 80, 80); run(400);

    // Reset in the middle of a multi-beat stream
    lane_en = 2'b11; knobs(90, 0, 100, 100, 100, 100);
    for (int i = 0; i < 500 && !(act[0] != 0 && beat[0] >= 1 && nbeats[0] >= 3); i++) cycle();
    do_reset();
    knobs(60, 10, 70, 70, 70, 70); run(300);

    // Drain all outstanding traffic within a bounded budget
    new_ok = 0; knobs(0, 0, 100, 100, 100, 100);
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      cycle();
      done = (act[0] == 0) && (act[1] == 0) && (owner_q.size() == 0) && (resp_hq.size() == 0);
    end
    check_eq("drain_complete", 128'(done), 128'(1));
    check_eq("lane0_all_responded", 128'(exp_seq[0]), 128'(seq[0]));
    check_eq("lane1_all_responded", 128'(exp_seq[1]), 128'(seq[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
